// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered MIPS decode stage with a 2-entry skid buffer; define DECODE_ILLEGAL_EN to flag unsupported opcodes/functs
module instr_decode_stage #(
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   Instr,
  input  logic [WL-1:0] PC,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    OPcode,
  output logic [5:0]    Func,
  output logic [4:0]    RS,
  output logic [4:0]    RT,
  output logic [4:0]    RD,
  output logic [4:0]    shamt,
  output logic [WL-1:0] ImmExt,
  output logic [WL-1:0] JumpAddr,
  output logic [1:0]    fmt,
  output logic [WL-1:0] out_pc,
  output logic          illegal
);
  typedef struct packed {
    logic [5:0]    op;
    logic [5:0]    fn;
    logic [19:0]   regs;
    logic [WL-1:0] imm;
    logic [WL-1:0] ja;
    logic [WL-1:0] pc;
    logic [1:0]    fmt;
    logic          ill;
  } ent_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  ent_t m_q, m_d, s_q, s_d, dec, o;
  logic out_valid_q, in_ready_q, take_in, take_out, ill;
  logic [5:0] op;
  logic [WL-1:0] se, imm;
  logic [WL-29:0] pc4_hi;
  assign op = Instr[31:26];
  assign se = {{(WL-16){Instr[15]}}, Instr[15:0]};
  assign imm = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {{(WL-16){1'b0}}, Instr[15:0]} :
               (op == 6'h0F) ? se << 16 : se;
  // Only the bits above 27 of PC+4 reach the jump target, so add just the carry into them.
  assign pc4_hi = PC[WL-1:28] + (WL-28)'(&PC[27:2]);
`ifdef DECODE_ILLEGAL_EN
  assign ill = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B}) ||
               (op == 6'h00 && !(Instr[5:0] inside {6'h00, 6'h02, 6'h08, 6'h20,
                                                   6'h22, 6'h24, 6'h25, 6'h2A}));
`else
  assign ill = 1'b0;
`endif
  assign dec = {op, Instr[5:0], Instr[25:6], imm, {pc4_hi, Instr[25:0], 2'b00}, PC,
                (op == 6'h00) ? 2'd0 : (op == 6'h02 || op == 6'h03) ? 2'd2 : 2'd1, ill};
  assign take_in  = in_valid & in_ready_q;
  assign take_out = out_valid_q & out_ready;
  always_comb begin
    state_d = flush ? EMPTY :
              state_q == EMPTY ? (take_in ? ONE : EMPTY) :
              state_q == ONE ? ((take_in && !take_out) ? FULL : (!take_in && take_out) ? EMPTY : ONE) :
              (take_out ? ONE : FULL);
    m_d = (state_q == FULL && take_out) ? s_q :
          (take_in && (state_q == EMPTY || take_out)) ? dec : m_q;
    s_d = (state_q == ONE && take_in && !take_out) ? dec : s_q;
  end
  always_ff @(posedge CLK) begin
    m_q <= m_d;
    s_q <= s_d;
    if (RST) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= state_d != EMPTY;
      in_ready_q  <= state_d != FULL;
    end
  end
  // Data registers keep stale contents across reset/flush; outputs read as zero while invalid.
  assign o = out_valid_q ? m_q : '0;
  assign {OPcode, Func, RS, RT, RD, shamt, ImmExt, JumpAddr, out_pc, fmt, illegal} = o;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed vectors with a queue scoreboard and an output monitor
module tb_instr_decode_stage;
  logic CLK = 0, RST = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] Instr = 0, PC = 0;
  logic in_ready, out_valid, illegal;
  logic [5:0] OPcode, Func;
  logic [4:0] RS, RT, RD, shamt;
  logic [31:0] ImmExt, JumpAddr, out_pc;
  logic [1:0] fmt;
  logic [130:0] out_bus;
  typedef struct packed {
    logic [31:0]  ins;
    logic [31:0]  pc;
    logic [130:0] exp;
  } vec_t;
  vec_t q[$];
  vec_t v[10];
  vec_t mv;
  int checks = 0, errors = 0;
`ifdef DECODE_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  instr_decode_stage #(.WL(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .PC(PC), .out_valid(out_valid), .out_ready(out_ready),
    .OPcode(OPcode), .Func(Func), .RS(RS), .RT(RT), .RD(RD), .shamt(shamt),
    .ImmExt(ImmExt), .JumpAddr(JumpAddr), .fmt(fmt), .out_pc(out_pc), .illegal(illegal)
  );

  always #5 CLK = ~CLK;
  assign out_bus = {OPcode, Func, RS, RT, RD, shamt, ImmExt, JumpAddr, out_pc, fmt, illegal};

  function automatic vec_t mk(logic [31:0] ins, logic [31:0] pc, logic [5:0] op, logic [5:0] fn,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh,
                              logic [31:0] imm, logic [31:0] ja, logic [1:0] f, logic il);
    return {ins, pc, {op, fn, rs, rt, rd, sh, imm, ja, pc, f, il}};
  endfunction

  task automatic chk(input string name, input logic [130:0] got, input logic [130:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t e);
    logic acc;
    int n = 0;
    Instr = e.ins; PC = e.pc; in_valid = 1;
    forever begin
      acc = in_ready;
      @(posedge CLK); #1;
      if (acc) break;
      if (++n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout got no acceptance expected accept of %h", e.ins);
        break;
      end
    end
    if (acc) q.push_back(e);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drain", 131'(q.size()), 131'(0));
  endtask

  always @(negedge CLK) begin
    if (out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got %h expected none", out_bus);
      end else begin
        mv = q.pop_front();
        checks--;
        chk("entry", out_bus, mv.exp);
      end
    end
  end

  initial begin
    v[0] = mk(32'h2008FFFC, 32'h00400000, 6'h08, 6'h3C, 0, 8, 31, 31, 32'hFFFFFFFC, 32'h0023FFF0, 2'd1, 0);
    v[1] = mk(32'h3C011234, 32'h00400004, 6'h0F, 6'h34, 0, 1, 2, 8, 32'h12340000, 32'h000448D0, 2'd1, 0);
    v[2] = mk(32'h3421ABCD, 32'h00400008, 6'h0D, 6'h0D, 1, 1, 21, 15, 32'h0000ABCD, 32'h0086AF34, 2'd1, 0);
    v[3] = mk(32'h0810000A, 32'h00400010, 6'h02, 6'h0A, 0, 16, 0, 0, 32'h0000000A, 32'h00400028, 2'd2, 0);
    v[4] = mk(32'h00221820, 32'h00400100, 6'h00, 6'h20, 1, 2, 3, 0, 32'h00001820, 32'h00886080, 2'd0, 0);
    v[5] = mk(32'h1022FFFE, 32'h00400104, 6'h04, 6'h3E, 1, 2, 31, 31, 32'hFFFFFFFE, 32'h008BFFF8, 2'd1, 0);
    v[6] = mk(32'h8C430008, 32'hF0000108, 6'h23, 6'h08, 2, 3, 0, 0, 32'h00000008, 32'hF10C0020, 2'd1, 0);
    v[7] = mk(32'h0BFFFFFF, 32'hFFFFFFFC, 6'h02, 6'h3F, 31, 31, 31, 31, 32'hFFFFFFFF, 32'h0FFFFFFC, 2'd2, 0);
    v[8] = mk(32'hFC000000, 32'h00400200, 6'h3F, 6'h00, 0, 0, 0, 0, 32'h00000000, 32'h00000000, 2'd1, ILL);
    v[9] = mk(32'h0000003F, 32'h00400204, 6'h00, 6'h3F, 0, 0, 0, 0, 32'h0000003F, 32'h000000FC, 2'd0, ILL);
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    chk("rst_valid", 131'(out_valid), 131'(0));
    chk("rst_ready", 131'(in_ready), 131'(1));
    chk("rst_data", out_bus, 131'(0));
    out_ready = 1;
    send(v[0]);
    chk("latency", 131'(out_valid), 131'(1));
    send(v[1]);
    send(v[2]);
    @(posedge CLK); #1;
    chk("bubble_after_pair", 131'(out_valid), 131'(0));
    send(v[3]);
    send(v[7]);
    send(v[8]);
    send(v[9]);
    drain();
    out_ready = 0;
    send(v[4]);
    send(v[5]);
    chk("full_ready", 131'(in_ready), 131'(0));
    fork
      send(v[6]);
      begin
        repeat (2) begin
          @(posedge CLK); #1;
          chk("stall_hold_A", out_bus, v[4].exp);
          chk("stall_ready", 131'(in_ready), 131'(0));
        end
        out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    send(v[0]);
    send(v[1]);
    Instr = v[2].ins; PC = v[2].pc; in_valid = 1; flush = 1;
    @(posedge CLK); #1;
    flush = 0; in_valid = 0;
    q.delete();
    chk("flush_valid", 131'(out_valid), 131'(0));
    chk("flush_ready", 131'(in_ready), 131'(1));
    out_ready = 1;
    repeat (5) @(posedge CLK);
    #1 out_ready = 0;
    send(v[3]);
    RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    q.delete();
    chk("midrst_valid", 131'(out_valid), 131'(0));
    chk("midrst_data", out_bus, 131'(0));
    out_ready = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", 131'(q.size()), 131'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
